vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Raster timing generator for the 640x480 @ 60 Hz display path. Produces pixel coordinates (DrawX, DrawY), the active-display flag (blank) and sync pulses that feed the sprite/ROM renderers and the RGB output stage. All outputs are registered and mutually aligned to the same pixel. Also provides a frame-start strobe and a free-running frame counter for animation and game-state updates.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
vga_clk  input  1  pixel clock (25 MHz nominal); the only clock
reset  input  1  synchronous, active-high reset
DrawX  output  10  current pixel column, 0..H_TOTAL-1
DrawY  output  10  current line, 0..V_TOTAL-1
blank  output  1  1 = pixel is in the visible region (renderers drive colour only when 1)
hs  output  1  horizontal sync, active-low
vs  output  1  vertical sync, active-low
frame_start  output  1  one-cycle strobe at DrawX=0, DrawY=0
frame_count  output  8  frames elapsed since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be <= 1024. Coordinate counters are 10 bits wide.
- Reset (sampled on posedge vga_clk while reset=1):
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524).
  - hs=1, vs=1, blank=0, frame_start=0, frame_count=0.
  - These values hold for as long as reset stays high.
- Counters, per posedge with reset=0:
  - DrawX increments. If DrawX == H_TOTAL-1, DrawX goes to 0 and DrawY advances.
  - DrawY advances by incrementing, or goes to 0 if DrawY == V_TOTAL-1.
  - The first edge after reset deasserts therefore yields DrawX=0, DrawY=0: a full frame starts immediately.
- Registered outputs:
  - All outputs are computed from the next counter values and registered on the same edge. In every cycle they describe the pixel at (DrawX, DrawY). Latency from counter to flags is 0.
  - blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
  - hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491). vs covers whole lines, including hblank.
  - frame_start = 1 exactly in the cycle where DrawX=0 and DrawY=0.
- frame_count:
  - Increments on the same edge that raises frame_start, so it reads 1 during the first frame after reset.
  - 8-bit wrap, 255 -> 0.
- Reset mid-frame: on the reset edge, every output jumps to its reset value with no partial-line completion. Restart behaves exactly as after power-up.
- No other inputs; no back-pressure. The block is free-running.
- Frame period is H_TOTAL*V_TOTAL = 420000 cycles. blank=1 for exactly 307200 cycles per frame.

Test Plan:
1. Reset values: hold reset 5 cycles -> DrawX=799, DrawY=524, hs=1, vs=1, blank=0, frame_start=0, frame_count=0. First edge with reset=0 -> DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1.
2. Horizontal timing: on line 0, check blank=1 at DrawX=639 and blank=0 at 640. Check hs=1 at 655, hs=0 at 656 and 751, hs=1 at 752. At DrawX=799 the next cycle gives DrawX=0, DrawY=1.
3. Vertical timing: blank=0 for the whole of DrawY=480. vs=1 on line 489, vs=0 for all 1600 cycles of lines 490-491, vs=1 on line 492. DrawY=524, DrawX=799 -> next cycle (0,0) with frame_start=1.
4. Frame counting: run 2 full frames -> exactly 420000 cycles between frame_start pulses, 307200 blank=1 cycles per frame, 96 hs-low cycles per line.
5. Wrap: run 256 frames from reset -> frame_count sequence 1..255, then 0 at the 256th frame_start.
6. Mid-frame reset: assert reset for 1 cycle at (DrawX=300, DrawY=200) -> outputs show reset values that cycle. The next cycle gives (0,0) with frame_start=1 and frame_count=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, visible-region flag, active-low syncs,
// a frame-start strobe and an 8-bit frame counter, all registered and mutually aligned.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis     = 10'(H_VISIBLE);
  localparam logic [9:0] VVis     = 10'(V_VISIBLE);
  localparam logic [9:0] HsStart  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HsEnd    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VsStart  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VsEnd    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] draw_x_q, draw_x_d;
  logic [9:0] draw_y_q, draw_y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Flags are derived from the next coordinates so they line up with the registered pixel.
  always_comb begin
    draw_x_d = draw_x_q + 10'd1;
    draw_y_d = draw_y_q;
    if (draw_x_q == HLast) begin
      draw_x_d = '0;
      draw_y_d = (draw_y_q == VLast) ? '0 : draw_y_q + 10'd1;
    end
    blank_d       = (draw_x_d < HVis) && (draw_y_d < VVis);
    hs_d          = !((draw_x_d >= HsStart) && (draw_x_d < HsEnd));
    vs_d          = !((draw_y_d >= VsStart) && (draw_y_d < VsEnd));
    frame_start_d = (draw_x_d == '0) && (draw_y_d == '0);
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  // Reset parks the counters on the last pixel so the first free edge lands on (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      draw_x_q      <= HLast;
      draw_y_q      <= VLast;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for reset and horizontal timing, and a
// scaled instance (10x8 raster) so vertical timing, frame counting and wrap fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } pix_t;

  logic       vga_clk;
  logic       reset;
  logic [9:0] fx, fy, sx, sy;
  logic       fblank, fhs, fvs, ffs, sblank, shs, svs, sfs;
  logic [7:0] ffc, sfc;

  int errors = 0;
  int checks = 0;
  int cyc = -1;
  bit run_chk = 0;

  vga_timing_gen u_full (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (fx),
    .DrawY       (fy),
    .blank       (fblank),
    .hs          (fhs),
    .vs          (fvs),
    .frame_start (ffs),
    .frame_count (ffc)
  );

  vga_timing_gen #(
    .H_VISIBLE (6), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) u_small (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (sx),
    .DrawY       (sy),
    .blank       (sblank),
    .hs          (shs),
    .vs          (svs),
    .frame_start (sfs),
    .frame_count (sfc)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Cycles since reset was released; -1 while held in reset.
  always @(posedge vga_clk) begin
    if (reset) cyc = -1;
    else       cyc = cyc + 1;
  end

  // Raster position follows directly from elapsed time since reset.
  function automatic pix_t model(input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input int c);
    pix_t p;
    int ht, vt, x, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (c < 0) begin
      p.x = 10'(ht - 1); p.y = 10'(vt - 1);
      p.blank = 1'b0; p.hs = 1'b1; p.vs = 1'b1; p.fs = 1'b0; p.fc = 8'd0;
    end else begin
      x = c % ht;
      y = (c / ht) % vt;
      p.x     = 10'(x);
      p.y     = 10'(y);
      p.blank = (x < hv) && (y < vv);
      p.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
      p.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
      p.fs    = (c % (ht * vt)) == 0;
      p.fc    = 8'(((c / (ht * vt)) + 1) % 256);
    end
    return p;
  endfunction

  task automatic cmp_pix(input string tag, input pix_t act, input pix_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, required x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
               tag, cyc, act.x, act.y, act.blank, act.hs, act.vs, act.fs, act.fc,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.fs, exp.fc);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge vga_clk) begin
    if (run_chk) begin
      cmp_pix("full_model", {fx, fy, fblank, fhs, fvs, ffs, ffc},
              model(640, 16, 96, 48, 480, 10, 2, 33, cyc));
      cmp_pix("small_model", {sx, sy, sblank, shs, svs, sfs, sfc},
              model(6, 1, 2, 1, 4, 1, 2, 1, cyc));
    end
  end

  initial begin
    int hs_low, blank_line, pulses, last_fs, blank_frame, vs_frame;
    bit done, found;
    hs_low = 0; blank_line = 0; pulses = 0; last_fs = 0;
    blank_frame = 0; vs_frame = 0; done = 0; found = 0;

    reset = 1'b1;
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    run_chk = 1;
    chk("rst_x", int'(fx), 799);
    chk("rst_y", int'(fy), 524);
    chk("rst_hs", int'(fhs), 1);
    chk("rst_vs", int'(fvs), 1);
    chk("rst_blank", int'(fblank), 0);
    chk("rst_fs", int'(ffs), 0);
    chk("rst_fc", int'(ffc), 0);
    chk("rst_small_xy", int'({sx, sy}), (9 << 10) | 7);

    reset = 1'b0;
    @(negedge vga_clk);
    chk("first_x", int'(fx), 0);
    chk("first_y", int'(fy), 0);
    chk("first_blank", int'(fblank), 1);
    chk("first_fs", int'(ffs), 1);
    chk("first_fc", int'(ffc), 1);

    // One pass over time: full-size line 0 checks plus scaled-raster frame statistics.
    for (int i = 0; i < 256 * 80 + 20 && !done; i++) begin
      if (cyc < 800) begin
        if (!fhs) hs_low++;
        if (fblank) blank_line++;
      end
      case (cyc)
        639: chk("h_blank_639", int'(fblank), 1);
        640: chk("h_blank_640", int'(fblank), 0);
        655: chk("h_hs_655", int'(fhs), 1);
        656: chk("h_hs_656", int'(fhs), 0);
        751: chk("h_hs_751", int'(fhs), 0);
        752: chk("h_hs_752", int'(fhs), 1);
        799: chk("h_x_799", int'(fx), 799);
        800: begin
          chk("h_wrap_x", int'(fx), 0);
          chk("h_wrap_y", int'(fy), 1);
          chk("h_hs_low_line0", hs_low, 96);
          chk("h_blank_line0", blank_line, 640);
        end
        45: chk("s_blank_line4", int'(sblank), 0);
        49: chk("s_vs_line4", int'(svs), 1);
        50: chk("s_vs_line5", int'(svs), 0);
        69: chk("s_vs_line6", int'(svs), 0);
        70: chk("s_vs_line7", int'(svs), 1);
        79: chk("s_last_xy", int'({sx, sy}), (9 << 10) | 7);
        80: chk("s_frame2_fs", int'(sfs), 1);
        default: ;
      endcase
      if (sfs) begin
        pulses++;
        chk("s_fc_seq", int'(sfc), pulses % 256);
        if (pulses > 1) begin
          chk("s_period", cyc - last_fs, 80);
          chk("s_blank_per_frame", blank_frame, 24);
          chk("s_vs_low_per_frame", vs_frame, 20);
        end
        last_fs = cyc;
        blank_frame = 0;
        vs_frame = 0;
        if (pulses == 256) done = 1;
      end
      if (sblank) blank_frame++;
      if (!svs) vs_frame++;
      if (!done) @(negedge vga_clk);
    end
    chk("s_256_frames_seen", pulses, 256);
    chk("s_wrap_fc", int'(sfc), 0);

    // Mid-frame reset at scaled (3,2).
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge vga_clk);
      if (sx == 10'd3 && sy == 10'd2) found = 1;
    end
    chk("mid_found", int'(found), 1);
    reset = 1'b1;
    @(negedge vga_clk);
    chk("mid_rst_s_xy", int'({sx, sy}), (9 << 10) | 7);
    chk("mid_rst_f_x", int'(fx), 799);
    chk("mid_rst_f_y", int'(fy), 524);
    chk("mid_rst_fc", int'(sfc), 0);
    chk("mid_rst_blank", int'(sblank), 0);
    reset = 1'b0;
    @(negedge vga_clk);
    chk("mid_restart_xy", int'({sx, sy}), 0);
    chk("mid_restart_fs", int'(sfs), 1);
    chk("mid_restart_fc", int'(sfc), 1);
    chk("mid_restart_full_fc", int'(ffc), 1);

    repeat (200) @(negedge vga_clk);
    run_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
